// File: rtl/cdb_complete_arbiter.sv
// Complete stage: per-FU result FIFOs drained round-robin onto CDB_WIDTH broadcast lanes.
// Lane outputs are driven only from queue heads, so there is no FU-to-CDB bypass.
module cdb_complete_arbiter #(
  parameter int unsigned N_FU      = 4,
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned Q_DEPTH   = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PHYS_REGS = 128,
  parameter int unsigned ROB_DEPTH = 64,
  localparam int unsigned PRF_W    = $clog2(PHYS_REGS),
  localparam int unsigned ROB_W    = $clog2(ROB_DEPTH)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                flush_i,
  input  logic [N_FU-1:0]                     fu_valid_i,
  input  logic [N_FU-1:0][XLEN-1:0]           fu_value_i,
  input  logic [N_FU-1:0][PRF_W-1:0]          fu_dest_prf_i,
  input  logic [N_FU-1:0][ROB_W-1:0]          fu_rob_idx_i,
  input  logic [N_FU-1:0]                     fu_exception_i,
  input  logic [N_FU-1:0]                     fu_mispred_i,
  output logic [N_FU-1:0]                     fu_ready_o,
  output logic [CDB_WIDTH-1:0]                cdb_valid_o,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]      cdb_value_o,
  output logic [CDB_WIDTH-1:0][PRF_W-1:0]     cdb_dest_prf_o,
  output logic [CDB_WIDTH-1:0][ROB_W-1:0]     cdb_rob_idx_o,
  output logic [CDB_WIDTH-1:0]                cdb_exception_o,
  output logic [CDB_WIDTH-1:0]                cdb_mispred_o
);

  localparam int unsigned PTR_W = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
  localparam int unsigned RR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [PRF_W-1:0] dest_prf;
    logic [ROB_W-1:0] rob_idx;
    logic             exception;
    logic             mispred;
  } entry_t;

  entry_t           mem_q   [N_FU][Q_DEPTH];
  logic [PTR_W-1:0] head_q  [N_FU];
  logic [PTR_W-1:0] tail_q  [N_FU];
  logic [CNT_W-1:0] count_q [N_FU];
  logic [RR_W-1:0]  rr_q, rr_d;

  entry_t           in_ent [N_FU];
  entry_t           lane   [CDB_WIDTH];
  logic [N_FU-1:0]  ready, push, grant;

  // Ready depends only on stored count; a dequeue this cycle does not reopen a full queue.
  always_comb begin
    for (int unsigned k = 0; k < N_FU; k++) begin
      ready[k]            = reset_n && (count_q[k] < CNT_W'(Q_DEPTH));
      in_ent[k].value     = fu_value_i[k];
      in_ent[k].dest_prf  = fu_dest_prf_i[k];
      in_ent[k].rob_idx   = fu_rob_idx_i[k];
      in_ent[k].exception = fu_exception_i[k];
      in_ent[k].mispred   = fu_mispred_i[k];
    end
  end

  assign fu_ready_o = ready;
  assign push       = fu_valid_i & ready;

  // Scan from rr_q, filling lanes in order with the first non-empty queues.
  always_comb begin
    logic [RR_W:0]   sum;
    logic [RR_W-1:0] idx;
    int unsigned     n;
    sum         = '0;
    idx         = '0;
    n           = 0;
    grant       = '0;
    cdb_valid_o = '0;
    rr_d        = rr_q;
    for (int unsigned l = 0; l < CDB_WIDTH; l++) lane[l] = '0;
    if (reset_n) begin
      for (int unsigned i = 0; i < N_FU; i++) begin
        sum = {1'b0, rr_q} + (RR_W + 1)'(i);
        if (sum >= (RR_W + 1)'(N_FU)) sum = sum - (RR_W + 1)'(N_FU);
        idx = sum[RR_W-1:0];
        if (count_q[idx] != '0 && n < CDB_WIDTH) begin
          grant[idx] = 1'b1;
          for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
            if (n == l) begin
              lane[l]        = mem_q[idx][head_q[idx]];
              cdb_valid_o[l] = 1'b1;
            end
          end
          rr_d = (idx == RR_W'(N_FU - 1)) ? '0 : idx + RR_W'(1);
          n    = n + 1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
      cdb_value_o[l]     = lane[l].value;
      cdb_dest_prf_o[l]  = lane[l].dest_prf;
      cdb_rob_idx_o[l]   = lane[l].rob_idx;
      cdb_exception_o[l] = lane[l].exception;
      cdb_mispred_o[l]   = lane[l].mispred;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush_i) begin
      rr_q <= '0;
      for (int unsigned k = 0; k < N_FU; k++) begin
        count_q[k] <= '0;
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int unsigned k = 0; k < N_FU; k++) begin
        if (push[k])  tail_q[k] <= tail_q[k] + PTR_W'(1);
        if (grant[k]) head_q[k] <= head_q[k] + PTR_W'(1);
        count_q[k] <= count_q[k] + CNT_W'(push[k]) - CNT_W'(grant[k]);
      end
    end
  end

  // Storage needs no reset: an entry is only read while its queue count covers it.
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < N_FU; k++) begin
      if (reset_n && !flush_i && push[k]) mem_q[k][tail_q[k]] <= in_ent[k];
    end
  end

  // Valid into a full queue is dropped; flag it in simulation.
  always @(posedge clock) begin
    for (int unsigned k = 0; k < N_FU; k++) begin
      if (reset_n && !flush_i && fu_valid_i[k]) assert (ready[k]);
    end
  end

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Self-checking bench for cdb_complete_arbiter: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_cdb_complete_arbiter;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int QD = 2;

  logic                  clock = 1'b0;
  logic                  reset_n, flush_i;
  logic [N-1:0]          fu_valid_i;
  logic [N-1:0][31:0]    fu_value_i;
  logic [N-1:0][6:0]     fu_dest_prf_i;
  logic [N-1:0][5:0]     fu_rob_idx_i;
  logic [N-1:0]          fu_exception_i, fu_mispred_i;
  logic [N-1:0]          fu_ready_o;
  logic [W-1:0]          cdb_valid_o;
  logic [W-1:0][31:0]    cdb_value_o;
  logic [W-1:0][6:0]     cdb_dest_prf_o;
  logic [W-1:0][5:0]     cdb_rob_idx_o;
  logic [W-1:0]          cdb_exception_o, cdb_mispred_o;

  cdb_complete_arbiter #(
    .N_FU(N), .CDB_WIDTH(W), .Q_DEPTH(QD), .XLEN(32), .PHYS_REGS(128), .ROB_DEPTH(64)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
    .fu_valid_i(fu_valid_i), .fu_value_i(fu_value_i), .fu_dest_prf_i(fu_dest_prf_i),
    .fu_rob_idx_i(fu_rob_idx_i), .fu_exception_i(fu_exception_i),
    .fu_mispred_i(fu_mispred_i), .fu_ready_o(fu_ready_o), .cdb_valid_o(cdb_valid_o),
    .cdb_value_o(cdb_value_o), .cdb_dest_prf_o(cdb_dest_prf_o),
    .cdb_rob_idx_o(cdb_rob_idx_o), .cdb_exception_o(cdb_exception_o),
    .cdb_mispred_o(cdb_mispred_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] v;
    logic [6:0]  p;
    logic [5:0]  r;
    logic        e;
    logic        m;
  } ent_t;

  ent_t mq [N][$];
  int   rr;
  int   errors = 0;
  int   checks = 0;
  int   saw_full;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the model: heads of the first W non-empty queues scanning from rr.
  task automatic check_outputs(input string tag);
    ent_t         exp_l [W];
    ent_t         obs;
    logic [W-1:0] exp_v;
    logic [N-1:0] exp_r;
    int           n, f;
    n     = 0;
    exp_v = '0;
    for (int l = 0; l < W; l++) exp_l[l] = '0;
    for (int k = 0; k < N; k++) exp_r[k] = reset_n && (mq[k].size() < QD);
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        f = (rr + i) % N;
        if (mq[f].size() > 0 && n < W) begin
          exp_l[n] = mq[f][0];
          exp_v[n] = 1'b1;
          n++;
        end
      end
    end
    chk({tag, "_ready"}, 64'(fu_ready_o), 64'(exp_r));
    chk({tag, "_valid"}, 64'(cdb_valid_o), 64'(exp_v));
    for (int l = 0; l < W; l++) begin
      obs = '{v: cdb_value_o[l], p: cdb_dest_prf_o[l], r: cdb_rob_idx_o[l],
              e: cdb_exception_o[l], m: cdb_mispred_o[l]};
      chk($sformatf("%s_lane%0d", tag, l), 64'(obs), 64'(exp_l[l]));
    end
  endtask

  task automatic update_model();
    bit [N-1:0] room, pop;
    int         n, f, last;
    n    = 0;
    last = -1;
    pop  = '0;
    if (!reset_n || flush_i) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      rr = 0;
    end else begin
      for (int k = 0; k < N; k++) room[k] = mq[k].size() < QD;
      for (int i = 0; i < N; i++) begin
        f = (rr + i) % N;
        if (mq[f].size() > 0 && n < W) begin
          pop[f] = 1'b1;
          last   = f;
          n++;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (pop[k]) void'(mq[k].pop_front());
        if (fu_valid_i[k] && room[k])
          mq[k].push_back('{v: fu_value_i[k], p: fu_dest_prf_i[k], r: fu_rob_idx_i[k],
                            e: fu_exception_i[k], m: fu_mispred_i[k]});
      end
      if (last >= 0) rr = (last + 1) % N;
    end
  endtask

  task automatic tick(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clock);
    update_model();
    #1;
  endtask

  // Valid is only raised where the model says the queue has room.
  task automatic set_in(input bit rn, input bit fl, input logic [N-1:0] vmask);
    reset_n = rn;
    flush_i = fl;
    for (int k = 0; k < N; k++) begin
      fu_valid_i[k]     = vmask[k] && rn && (mq[k].size() < QD);
      fu_value_i[k]     = $urandom;
      fu_dest_prf_i[k]  = 7'($urandom_range(0, 127));
      fu_rob_idx_i[k]   = 6'($urandom_range(0, 63));
      fu_exception_i[k] = 1'($urandom);
      fu_mispred_i[k]   = 1'($urandom);
    end
  endtask

  initial begin
    rr = 0;
    set_in(0, 0, '0);
    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) tick("reset");
    chk("reset_ready", 64'(fu_ready_o), 64'h0);
    set_in(1, 0, '0);
    tick("release");
    chk("release_ready", 64'(fu_ready_o), 64'hF);

    // Contention: all four FUs at once with rr at 0.
    set_in(1, 0, 4'hF);
    for (int k = 0; k < N; k++) fu_rob_idx_i[k] = 6'(10 + k);
    tick("cont_in");
    set_in(1, 0, '0);
    #1;
    chk("cont_t1_valid", 64'(cdb_valid_o), 64'h3);
    chk("cont_t1_rob0", 64'(cdb_rob_idx_o[0]), 64'd10);
    chk("cont_t1_rob1", 64'(cdb_rob_idx_o[1]), 64'd11);
    tick("cont_t1");
    #1;
    chk("cont_t2_rob0", 64'(cdb_rob_idx_o[0]), 64'd12);
    chk("cont_t2_rob1", 64'(cdb_rob_idx_o[1]), 64'd13);
    tick("cont_t2");
    #1;
    chk("cont_t3_valid", 64'(cdb_valid_o), 64'h0);
    tick("cont_t3");

    // Single result on FU2.
    set_in(1, 0, 4'b0100);
    fu_value_i[2]    = 32'h1234;
    fu_dest_prf_i[2] = 7'd5;
    fu_rob_idx_i[2]  = 6'd9;
    tick("single_in");
    set_in(1, 0, '0);
    #1;
    chk("single_valid", 64'(cdb_valid_o), 64'h1);
    chk("single_value", 64'(cdb_value_o[0]), 64'h1234);
    chk("single_prf", 64'(cdb_dest_prf_o[0]), 64'd5);
    chk("single_rob", 64'(cdb_rob_idx_o[0]), 64'd9);
    tick("single_out");
    chk("single_rr", 64'(dut.rr_q), 64'd3);

    // Backpressure: every FU busy so FU1 fills up.
    saw_full = 0;
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 4'hF);
      #1;
      if (fu_ready_o[1] === 1'b0) saw_full++;
      tick("bp");
    end
    chk("bp_full_seen", 64'(saw_full != 0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, '0);
      tick("bp_drain");
    end
    chk("bp_drained", 64'(cdb_valid_o), 64'h0);

    // Flush with three queued results and FU0 presenting a new one.
    set_in(1, 0, 4'b0111);
    tick("flush_fill");
    set_in(1, 1, 4'b0001);
    fu_value_i[0] = 32'hDEAD_BEEF;
    tick("flush_cyc");
    set_in(1, 0, '0);
    #1;
    chk("flush_valid", 64'(cdb_valid_o), 64'h0);
    chk("flush_ready", 64'(fu_ready_o), 64'hF);
    for (int i = 0; i < 3; i++) tick("flush_after");

    // Mid-operation reset.
    set_in(1, 0, 4'hF);
    tick("mid_fill");
    set_in(0, 0, 4'hF);
    tick("mid_rst");
    chk("mid_rr", 64'(dut.rr_q), 64'd0);
    set_in(1, 0, '0);
    for (int i = 0; i < 3; i++) tick("mid_after");

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 50) != 0, ($urandom % 25) == 0, 4'($urandom));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
